// File: rtl/ota_dec_pkg.sv
// Shared types and constants for the OTA density decimator: FSM states,
// window-length lookup and output saturation.
package ota_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [8:0] WIN_LEN_0 = 9'd32;
  localparam logic [8:0] WIN_LEN_1 = 9'd64;
  localparam logic [8:0] WIN_LEN_2 = 9'd128;
  localparam logic [8:0] WIN_LEN_3 = 9'd256;

  localparam logic [8:0] SAT_MAX = 9'd255;

  // Index of the final sample in a window (N-1), sized for the 8-bit index.
  function automatic logic [7:0] win_last(input logic [1:0] sel);
    logic [8:0] n;
    logic [8:0] n_m1;
    case (sel)
      2'd0:    n = WIN_LEN_0;
      2'd1:    n = WIN_LEN_1;
      2'd2:    n = WIN_LEN_2;
      default: n = WIN_LEN_3;
    endcase
    n_m1 = n - 9'd1;
    return n_m1[7:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return (v > SAT_MAX) ? SAT_MAX[7:0] : v[7:0];
  endfunction

endpackage

// File: rtl/ota_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// SYNC_STAGES must be at least 2.
module ota_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/ota_density_decimator.sv
// Measures ones-density and transition count of a synchronized comparator
// output over back-to-back windows of 32/64/128/256 samples.
//
//   state | meaning
//   IDLE  | not measuring; s_prev still tracks s, outputs hold
//   ACCUM | accumulating samples of the current window
module ota_density_decimator
  import ota_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmp_in,
  input  logic       en,
  input  logic [1:0] win_sel,
  output logic [7:0] density,
  output logic [7:0] toggles,
  output logic       valid,
  output logic       busy
);

  state_t     state, state_nxt;
  logic       s, s_prev;
  logic [8:0] ones, edges;
  logic [8:0] ones_nxt, edges_nxt;
  logic [7:0] idx, last_idx;
  logic       start, step, done;

  ota_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (cmp_in),
    .q  (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    ones_nxt  = ones + {8'd0, s};
    edges_nxt = edges + {8'd0, s ^ s_prev};
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = ACCUM;
          start     = 1'b1;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          done = (idx == last_idx);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The window-closing edge also restarts counters, so windows abut with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev   <= 1'b0;
      ones     <= '0;
      edges    <= '0;
      idx      <= '0;
      last_idx <= '0;
      density  <= '0;
      toggles  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      s_prev <= s;
      valid  <= 1'b0;
      busy   <= (state_nxt == ACCUM);
      if (start || done) begin
        ones     <= '0;
        edges    <= '0;
        idx      <= '0;
        last_idx <= win_last(win_sel);
      end else if (step) begin
        ones  <= ones_nxt;
        edges <= edges_nxt;
        idx   <= idx + 8'd1;
      end
      if (done) begin
        density <= sat8(ones_nxt);
        toggles <= sat8(edges_nxt);
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ota_density_decimator.md
OTA_DENSITY_DECIMATOR -- requirements
Module: ota_density_decimator

Interface
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, meaning the number of flops in the cmp_in synchronizer (minimum 2).
REQ-002 The block SHALL provide port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-004 The block SHALL provide port cmp_in, input, 1 bit, meaning the asynchronous comparator/OTA digital output to be measured.
REQ-005 The block SHALL provide port en, input, 1 bit, meaning measurement enable; level sensitive.
REQ-006 The block SHALL provide port win_sel, input, 2 bits, meaning window length N: 0=32, 1=64, 2=128, 3=256 samples.
REQ-007 The block SHALL provide port density, output, 8 bits, meaning the count of synchronized 1-samples in the last completed window, saturated to 255.
REQ-008 The block SHALL provide port toggles, output, 8 bits, meaning the count of synchronized transitions in the last completed window, saturated to 255.
REQ-009 The block SHALL provide port valid, output, 1 bit, meaning a one-cycle pulse when density/toggles update.
REQ-010 The block SHALL provide port busy, output, 1 bit, meaning high while in state ACCUM.

Function
REQ-011 cmp_in SHALL pass through a SYNC_STAGES flop synchronizer before any use; its output is "s", latency SYNC_STAGES cycles.
REQ-012 A register "s_prev" SHALL capture s every cycle in all states, including IDLE.
REQ-013 The FSM SHALL have exactly two states: IDLE and ACCUM.
REQ-014 IDLE with en=1 SHALL transition to ACCUM next edge, clearing ones/edge/index counters and latching N from win_sel.
REQ-015 In ACCUM each edge SHALL add s to a 9-bit ones counter, add (s != s_prev) to a 9-bit edge counter, and increment the sample index.
REQ-016 On the edge absorbing the Nth sample, density and toggles SHALL load min(count including that sample, 255), and valid SHALL be 1 for the following cycle only.
REQ-017 Windows SHALL run back-to-back: on that same edge counters restart for the next window with no gap cycle, and N is re-latched from win_sel.
REQ-018 win_sel changes mid-window SHALL NOT affect the window in progress.
REQ-019 en=0 sampled in ACCUM SHALL return the FSM to IDLE next edge, discard the partial window, and produce no valid pulse.
REQ-020 density and toggles SHALL hold their last values between updates and while in IDLE.
REQ-021 The first transition compare of any window SHALL use s_prev from the preceding cycle (continuity across windows).
REQ-022 busy SHALL equal (state == ACCUM), registered.

Reset
REQ-023 rst=1 SHALL immediately and asynchronously force state IDLE and all synchronizer flops, s_prev, counters, density, toggles, valid, busy to 0.
REQ-024 Reset asserted mid-window SHALL discard that window; no valid pulse SHALL follow reset release until a full new window completes.
REQ-025 Reset release SHALL be treated as synchronous to clk by the integrator; the block adds no reset synchronizer.

Structure
REQ-026 A package ota_dec_pkg SHALL hold the state enumeration, the win_sel-to-N lookup constants (32/64/128/256), and the 255 saturation constant.
REQ-027 The synchronizer SHALL be a separate sub-module named ota_sync, parameterized by SYNC_STAGES, reset asynchronously to 0.
REQ-028 The FSM, counters and output registers SHALL reside in ota_density_decimator; no other sub-modules.

Verification
REQ-029 cmp_in=1 constant, win_sel=0, en=1 after sync settle -> valid every 32 cycles, density=32, toggles=0.
REQ-030 cmp_in toggling every clk, win_sel=1 -> steady-state windows density=32, toggles=64, valid period 64 cycles.
REQ-031 cmp_in=1 constant, win_sel=3 -> density=255 (saturated), toggles=0, valid period 256.
REQ-032 en dropped after sample 10 of a win_sel=0 window -> busy falls next edge, no valid, density/toggles hold prior values.
REQ-033 rst pulsed mid-window between clock edges -> all outputs 0 before next edge; first valid after release only after a full window.
REQ-034 win_sel changed 0->2 at sample 5 -> current window completes at 32 samples, next window uses 128.
